// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional error checking is enabled with the DMEM_ERR_CHECK_EN macro.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam int DMEM_LATENCY = 2;

  // Naturally aligned byte, halfword or word pattern; all-zero counts as a legal no-op.
  function automatic logic be_legal(input logic [3:0] be);
    return (be == 4'b0000) || (be == BE_WORD) ||
           (be == BE_HALF) || (be == 4'(BE_HALF << 2)) ||
           (be == BE_BYTE) || (be == 4'(BE_BYTE << 1)) ||
           (be == 4'(BE_BYTE << 2)) || (be == 4'(BE_BYTE << 3));
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response channel between a core load/store unit and the data-memory responder.
interface dmem_if;
  import dmem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_bytewrite_array.sv
// Word storage with per-byte write enables, asynchronous clear and combinational read.
// Latency: writes land on the clock edge; read data is combinational from addr.
// Backpressure: none; the owner decides when wbe is non-zero.
module dmem_bytewrite_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store in flight, LATENCY wait states, then a held response.
// Latency: rsp_valid rises LATENCY+1 cycles after the accept edge; throughput one per LATENCY+2.
// Backpressure: response held stable until rsp_ready; req_ready low until it retires. Optional DMEM_ERR_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = DMEM_LATENCY
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int NB = DATA_W / 8;

  dmem_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept, commit, req_ready;

  logic              we_q, oor_q, err_q;
  logic [ADDR_W-1:0] idx_q;
  logic [NB-1:0]     be_q;
  logic [DATA_W-1:0] wdata_q;

  logic              live_oor, live_err;
  logic              a_we, a_oor, a_err;
  logic [ADDR_W-1:0] a_idx;
  logic [NB-1:0]     a_be;
  logic [DATA_W-1:0] a_wdata;

  logic [NB-1:0]     mem_wbe;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rdata_q;
  logic              rsp_err_q;

  assign live_oor = |bus.req_addr[31:ADDR_W+2];

`ifdef DMEM_ERR_CHECK_EN
  assign live_err = live_oor ||
                    (bus.req_we ? !be_legal(bus.req_be) : (bus.req_addr[1:0] != 2'b00));
`else
  assign live_err = 1'b0;
`endif

  // A zero-latency access commits on its accept edge, before anything is latched.
  always_comb begin
    if (state_q == IDLE) begin
      a_we    = bus.req_we;
      a_idx   = bus.req_addr[ADDR_W+1:2];
      a_oor   = live_oor;
      a_be    = bus.req_be;
      a_wdata = bus.req_wdata;
      a_err   = live_err;
    end else begin
      a_we    = we_q;
      a_idx   = idx_q;
      a_oor   = oor_q;
      a_be    = be_q;
      a_wdata = wdata_q;
      a_err   = err_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        oor_q   <= live_oor;
        err_q   <= live_err;
        idx_q   <= bus.req_addr[ADDR_W+1:2];
        be_q    <= bus.req_be;
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        rdata_q   <= (a_we || a_oor) ? '0 : mem_rdata;
        rsp_err_q <= a_err;
      end
    end
  end

  // Out-of-range and flagged stores are dropped but still answered.
  assign mem_wbe = (commit && a_we && !a_oor && !a_err) ? a_be : '0;

  dmem_bytewrite_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .addr  (a_idx),
    .wbe   (mem_wbe),
    .wdata (a_wdata),
    .rdata (mem_rdata)
  );

  assign req_ready     = (state_q == IDLE) && rst;
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a LATENCY=2 responder and a LATENCY=0 responder share stimulus, selected by sel.
module tb_dmem_responder;
  import dmem_pkg::*;

`ifdef DMEM_ERR_CHECK_EN
  localparam logic        EXP_ERR  = 1'b1;
  localparam logic [31:0] EXP_W10 = 32'hDEADBEEF;
`else
  localparam logic        EXP_ERR  = 1'b0;
  localparam logic [31:0] EXP_W10 = 32'hDE5555EF;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [3:0]  req_be    = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_if if0 ();
  dmem_if if1 ();

  assign if0.req_valid = req_valid & ~sel;
  assign if1.req_valid = req_valid & sel;
  assign if0.req_we    = req_we;
  assign if1.req_we    = req_we;
  assign if0.req_addr  = req_addr;
  assign if1.req_addr  = req_addr;
  assign if0.req_be    = req_be;
  assign if1.req_be    = req_be;
  assign if0.req_wdata = req_wdata;
  assign if1.req_wdata = req_wdata;
  assign if0.rsp_ready = rsp_ready;
  assign if1.rsp_ready = rsp_ready;

  assign req_ready = sel ? if1.req_ready : if0.req_ready;
  assign rsp_valid = sel ? if1.rsp_valid : if0.rsp_valid;
  assign rsp_rdata = sel ? if1.rsp_rdata : if0.rsp_rdata;
  assign rsp_err   = sel ? if1.rsp_err   : if0.rsp_err;

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(2)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(0)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  // Issues one request, returns at the first negedge where rsp_valid is seen.
  // With hold=0 the response is consumed and the task returns just after that edge.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic hold,
                           output logic [31:0] rdata, output logic err, output int lat);
    int n;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wdata;
    req_valid = 1'b1;
    rsp_ready = !hold;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, want 1", req_ready, n);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, want 1", rsp_valid, lat);
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    if (!hold) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    sel = 1'b0;
    do_access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency: got %0d want 3", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h want 0", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL store_err: got %b want 0", er); end
    do_access(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_10: got %h want deadbeef", rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency: got %0d want 3", lat); end
  endtask

  task automatic test_byte_merge();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, rd, er, lat);
    do_access(1'b1, 32'h20, 4'b0100, 32'h00AA0000, 1'b0, rd, er, lat);
    do_access(1'b0, 32'h20, 4'h0, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL byte_merge: got %h want 11aa3344", rd); end
    do_access(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 1'b0, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL be0_err: got %b want 0", er); end
    do_access(1'b1, 32'h1020, 4'hF, 32'hFFFFFFFF, 1'b0, rd, er, lat);
    checks++; if (er !== EXP_ERR) begin errors++; $display("FAIL oor_store_err: got %b want %b", er, EXP_ERR); end
    do_access(1'b0, 32'h20, 4'h0, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL be0_oor_unchanged: got %h want 11aa3344", rd); end
    do_access(1'b0, 32'h1020, 4'h0, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_load_rdata: got %h want 0", rd); end
    do_access(1'b1, 32'hFFC, 4'hF, 32'hA5A5A5A5, 1'b0, rd, er, lat);
    do_access(1'b0, 32'hFFC, 4'h0, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL top_word: got %h want a5a5a5a5", rd); end
    do_access(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL word0_untouched: got %h want 0", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b0, 32'h10, 4'h0, 32'h0, 1'b1, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL bp_latency: got %0d want 3", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, rsp_valid); end
      checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_hold_rdata[%0d]: got %h want deadbeef", i, rsp_rdata); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", rsp_valid); end
  endtask

  task automatic test_err_check();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b0, 32'h13, 4'h0, 32'h0, 1'b0, rd, er, lat);
    checks++; if (er !== EXP_ERR) begin errors++; $display("FAIL misaligned_load_err: got %b want %b", er, EXP_ERR); end
`ifndef DMEM_ERR_CHECK_EN
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL misaligned_load_rdata: got %h want deadbeef", rd); end
`endif
    do_access(1'b1, 32'h10, 4'b0110, 32'h55555555, 1'b0, rd, er, lat);
    checks++; if (er !== EXP_ERR) begin errors++; $display("FAIL bad_be_err: got %b want %b", er, EXP_ERR); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bad_be_rdata: got %h want 0", rd); end
    do_access(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== EXP_W10) begin errors++; $display("FAIL bad_be_mem: got %h want %h", rd, EXP_W10); end
    do_access(1'b0, 32'h10000, 4'h0, 32'h0, 1'b0, rd, er, lat);
    checks++; if (er !== EXP_ERR) begin errors++; $display("FAIL oor_load_err: got %b want %b", er, EXP_ERR); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_load_10000: got %h want 0", rd); end
  endtask

  task automatic test_latency0();
    logic [31:0] rd; logic er; int lat;
    int nv, nr;
    sel = 1'b1;
    do_access(1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 1'b0, rd, er, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL l0_store_latency: got %0d want 1", lat); end
    do_access(1'b0, 32'h30, 4'h0, 32'h0, 1'b0, rd, er, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL l0_load_latency: got %0d want 1", lat); end
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL l0_load_rdata: got %h want cafef00d", rd); end
    // Continuous requests with an always-ready consumer.
    req_we = 1'b0; req_addr = 32'h30; req_valid = 1'b1; rsp_ready = 1'b1;
    nv = 0; nr = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) nv++;
      if (req_ready) nr++;
    end
    req_valid = 1'b0;
    checks++; if (nv !== 4) begin errors++; $display("FAIL l0_b2b_responses: got %0d want 4", nv); end
    checks++; if (nr !== 4) begin errors++; $display("FAIL l0_b2b_accepts: got %0d want 4", nr); end
    @(posedge clk);
    #1 sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    sel = 1'b0;
    do_access(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, rd, er, lat);
    req_we = 1'b1; req_addr = 32'h40; req_be = 4'hF; req_wdata = 32'h12345678;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", req_ready); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL mid_rst_rdata: got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b want 0", rsp_err); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    do_access(1'b0, 32'h40, 4'h0, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_rst_load40: got %h want 0", rd); end
    do_access(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_rst_cleared10: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_merge();
    test_backpressure();
    test_err_check();
    test_latency0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule
